phase_frame_rx: RTL and testbench

PHASE_FRAME_RX -- requirements
Module: phase_frame_rx

---
 rtl/phase_frame_rx.sv | 171 +++++++++++++++++
 tb/tb_phase_frame_rx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_frame_rx.sv
// Receives six-word tagged frames from a non-showahead FIFO and presents the
// header plus five channel payloads as one frame with valid/ready handoff.
module phase_frame_rx #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fifo_empty,
  input  logic [17:0]      fifo_rdata,
  output logic             fifo_rden,
  output logic [15:0]      out_hdr,
  output logic [79:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ASM  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [1:0] TAG_CH   = 2'b00;
  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_LAST = 2'b10;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic        rd_pend_reg;
  logic        rden_reg, rden_next;
  logic [15:0] hdr_shadow_reg;
  logic [63:0] ch_shadow;
  logic [1:0]  tag;
  logic [15:0] payload;
  logic        hdr_load, ch_store, frame_done, err_event;

  assign tag     = fifo_rdata[17:16];
  assign payload = fifo_rdata[15:0];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hdr_load   = 1'b0;
    ch_store   = 1'b0;
    frame_done = 1'b0;
    err_event  = 1'b0;
    case (state_reg)
      HUNT: begin
        if (rd_pend_reg) begin
          if (tag == TAG_HDR) begin
            hdr_load   = 1'b1;
            idx_next   = 3'd0;
            state_next = ASM;
          end else begin
            err_event = 1'b1;
          end
        end
      end
      ASM: begin
        if (rd_pend_reg) begin
          case (tag)
            TAG_CH: begin
              if (idx_reg == 3'd4) begin
                err_event  = 1'b1;
                state_next = HUNT;
              end else begin
                ch_store = 1'b1;
                idx_next = idx_reg + 3'd1;
              end
            end
            TAG_LAST: begin
              if (idx_reg == 3'd4) begin
                frame_done = 1'b1;
                state_next = OUT;
              end else begin
                err_event  = 1'b1;
                state_next = HUNT;
              end
            end
            TAG_HDR: begin
              // A new header mid-frame restarts assembly on that header.
              err_event = 1'b1;
              hdr_load  = 1'b1;
              idx_next  = 3'd0;
            end
            default: begin
              err_event  = 1'b1;
              state_next = HUNT;
            end
          endcase
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // One read in flight at most, so a returning word never lands in OUT.
  assign rden_next = !fifo_empty && !rden_reg && !rd_pend_reg && (state_reg != OUT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= HUNT;
      idx_reg     <= 3'd0;
      rd_pend_reg <= 1'b0;
      rden_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      rd_pend_reg <= rden_reg;
      rden_reg    <= rden_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hdr_shadow_reg <= 16'd0;
    end else if (hdr_load) begin
      hdr_shadow_reg <= payload;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      logic [15:0] ch_reg;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          ch_reg <= 16'd0;
        end else if (ch_store && (idx_reg == 3'(gi))) begin
          ch_reg <= payload;
        end
      end
      assign ch_shadow[gi*16 +: 16] = ch_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_hdr   <= 16'd0;
      out_data  <= 80'd0;
      out_valid <= 1'b0;
    end else if (frame_done) begin
      out_hdr   <= hdr_shadow_reg;
      out_data  <= {payload, ch_shadow};
      out_valid <= 1'b1;
    end else if (state_reg == OUT && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (err_event && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign fifo_rden = rden_reg;
  assign locked    = (state_reg != HUNT);

endmodule

// File: tb/tb_phase_frame_rx.sv
// Bench for phase_frame_rx: directed frame tables, back-pressure, saturation,
// reset and randomized word streams scored against a frame-level model.
module tb_phase_frame_rx;

  logic        clk;
  logic        resetn;
  logic        fifo_empty;
  logic [17:0] fifo_rdata;
  logic        fifo_rden;
  logic [15:0] out_hdr;
  logic [79:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clr_err;
  logic [15:0] err_cnt;
  logic        locked;
  logic        rden2, valid2, locked2;
  logic [15:0] hdr2;
  logic [79:0] data2;
  logic [1:0]  err_small;

  phase_frame_rx #(.ERR_W(16)) dut (
    .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rden(fifo_rden), .out_hdr(out_hdr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .clr_err(clr_err), .err_cnt(err_cnt), .locked(locked)
  );

  phase_frame_rx #(.ERR_W(2)) dut_w2 (
    .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rden(rden2), .out_hdr(hdr2), .out_data(data2), .out_valid(valid2),
    .out_ready(out_ready), .clr_err(clr_err), .err_cnt(err_small), .locked(locked2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Non-showahead FIFO: the popped word appears the cycle after the strobe.
  logic [17:0] fifo_q[$];
  initial begin
    fifo_rdata = 18'd0;
    fifo_empty = 1'b1;
  end
  always @(posedge clk) begin
    if (fifo_rden && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int last_rden_cyc = 0;
  int rd_count = 0;
  int frames_seen = 0;
  int valid_cycles = 0;
  bit prev_valid = 0;
  bit prev_acc = 0;
  logic [95:0] prev_word = '0;

  // Reference model: frame rules applied to the word stream in order.
  int          m_err = 0;
  bit          m_in = 0;
  logic [15:0] m_hdr = '0;
  logic [15:0] m_ch[$];
  logic [95:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic model_word(input logic [17:0] w);
    logic [15:0] p;
    p = w[15:0];
    case (w[17:16])
      2'b01: begin
        if (m_in) m_err++;
        m_in = 1;
        m_hdr = p;
        m_ch.delete();
      end
      2'b00: begin
        if (!m_in) m_err++;
        else if (m_ch.size() == 4) begin m_err++; m_in = 0; end
        else m_ch.push_back(p);
      end
      2'b10: begin
        if (m_in && m_ch.size() == 4) exp_q.push_back({m_hdr, p, m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
        else m_err++;
        m_in = 0;
      end
      default: begin m_err++; m_in = 0; end
    endcase
  endtask

  task automatic push_word(input logic [17:0] w);
    fifo_q.push_back(w);
    model_word(w);
  endtask

  task automatic monitor();
    if (!resetn) begin
      prev_valid = 0;
      prev_acc = 0;
      return;
    end
    if (fifo_rden) begin
      last_rden_cyc = cyc;
      rd_count++;
    end
    if (out_valid) begin
      valid_cycles++;
      chk("rden_in_hold", 96'(fifo_rden), 96'(0));
      chk("locked_in_out", 96'(locked), 96'(1));
      if (!prev_valid) chk("latency", 96'(cyc - last_rden_cyc), 96'(2));
      else if (!prev_acc) chk("hold_stable", {out_hdr, out_data}, prev_word);
      if (out_ready) begin
        frames_seen++;
        $display("frame hdr=%h data=%h cycle=%0d", out_hdr, out_data, cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_frame: got %h expected none", {out_hdr, out_data});
        end else begin
          chk("frame", {out_hdr, out_data}, exp_q.pop_front());
        end
      end
    end
    prev_valid = out_valid;
    prev_acc = out_valid && out_ready;
    prev_word = {out_hdr, out_data};
  endtask

  // Inputs change at the falling edge only; the monitor sees what the next rising edge sees.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    monitor();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !out_valid) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) fail_now("drain_timeout");
    repeat (4) tick();
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_err = 0;
  endtask

  function automatic logic [95:0] sat(input int e, input int mx);
    return 96'((e > mx) ? mx : e);
  endfunction

  typedef struct {
    int          start;
    int          n;
    logic [15:0] hdr;
    logic [79:0] data;
    int          err;
    int          frames;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] wl [0:30];
    vec_t        vt [0:2];
    logic [17:0] seg[$];
    logic [17:0] t;
    int          k, fs, vc, rb;

    wl = '{18'h10A5A, 18'h01111, 18'h02222, 18'h03333, 18'h04444, 18'h25555,
           18'h01234, 18'h11000, 18'h02000, 18'h23000,
           18'h14000, 18'h05001, 18'h05002, 18'h05003, 18'h05004, 18'h05005,
           18'h36000,
           18'h17777, 18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h20005,
           18'h1AAAA, 18'h00001, 18'h1BBBB, 18'h00011, 18'h00022, 18'h00033, 18'h00044, 18'h20055};
    vt[0] = '{0, 6, 16'h0A5A, 80'h5555_4444_3333_2222_1111, 0, 1};
    vt[1] = '{6, 17, 16'h7777, 80'h0005_0004_0003_0002_0001, 4, 1};
    vt[2] = '{23, 8, 16'hBBBB, 80'h0055_0044_0033_0022_0011, 1, 1};

    resetn = 1'b0;
    clr_err = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hdr_data", {out_hdr, out_data}, 96'(0));
    chk("reset_flags", 96'({out_valid, locked, fifo_rden, err_cnt}), 96'(0));
    resetn = 1'b1;

    // Directed frame tables with always-ready consumer.
    for (int v = 0; v < 3; v++) begin
      clr_pulse();
      fs = frames_seen;
      vc = valid_cycles;
      for (int i = 0; i < vt[v].n; i++) push_word(wl[vt[v].start + i]);
      drain(400);
      chk($sformatf("v%0d_err", v), 96'(err_cnt), 96'(vt[v].err));
      chk($sformatf("v%0d_err_w2", v), 96'(err_small), sat(vt[v].err, 3));
      chk($sformatf("v%0d_out", v), {out_hdr, out_data}, {vt[v].hdr, vt[v].data});
      chk($sformatf("v%0d_out_w2", v), {hdr2, data2}, {vt[v].hdr, vt[v].data});
      chk($sformatf("v%0d_frames", v), 96'(frames_seen - fs), 96'(vt[v].frames));
      chk($sformatf("v%0d_valid_cycles", v), 96'(valid_cycles - vc), 96'(vt[v].frames));
      chk($sformatf("v%0d_idle", v), 96'({out_valid, locked, fifo_rden, valid2, locked2, rden2}), 96'(0));
    end

    // Back-pressure: hold a frame for 10 cycles with the next frame queued.
    clr_pulse();
    ready_mode = 1;
    push_word(18'h1ABCD);
    for (int i = 1; i <= 4; i++) push_word({2'b00, 16'hA000 + 16'(i)});
    push_word(18'h2A005);
    push_word(18'h1BCDE);
    for (int i = 1; i <= 4; i++) push_word({2'b00, 16'hB000 + 16'(i)});
    push_word(18'h2B005);
    k = 0;
    while (!out_valid && k < 60) begin tick(); k++; end
    if (k >= 60) fail_now("bp_wait_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_held", 96'(out_valid), 96'(1));
    end
    chk("bp_no_reads", 96'(fifo_q.size()), 96'(6));
    chk("bp_held_frame", {out_hdr, out_data}, {16'hABCD, 80'hA005_A004_A003_A002_A001});
    ready_mode = 0;
    drain(400);
    chk("bp_next_frame", {out_hdr, out_data}, {16'hBCDE, 80'hB005_B004_B003_B002_B001});
    chk("bp_err", 96'(err_cnt), 96'(0));

    // Saturation of the narrow counter, then clear racing an error.
    clr_pulse();
    for (int i = 0; i < 5; i++) push_word({2'b00, 16'h0100 + 16'(i)});
    drain(200);
    chk("sat_err16", 96'(err_cnt), 96'(5));
    chk("sat_err2", 96'(err_small), 96'(3));
    push_word(18'h00999);
    k = 0;
    while (!fifo_rden && k < 20) begin tick(); k++; end
    if (k >= 20) fail_now("clr_wait_rden");
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m_err = 0;
    repeat (3) tick();
    chk("clr_wins_err16", 96'(err_cnt), 96'(0));
    chk("clr_wins_err2", 96'(err_small), 96'(0));

    // Asynchronous reset in the middle of a frame.
    rb = rd_count;
    push_word(18'h000FF);
    push_word(18'h11234);
    push_word(18'h00001);
    push_word(18'h00002);
    k = 0;
    while (rd_count - rb < 4 && k < 60) begin tick(); k++; end
    if (k >= 60) fail_now("rst_wait_reads");
    repeat (2) tick();
    chk("rst_pre_locked", 96'(locked), 96'(1));
    chk("rst_pre_err", 96'(err_cnt), 96'(1));
    #2 resetn = 1'b0;
    #1;
    chk("rst_hdr_data", {out_hdr, out_data}, 96'(0));
    chk("rst_flags", 96'({out_valid, locked, fifo_rden, err_cnt, err_small}), 96'(0));
    m_in = 0;
    m_ch.delete();
    m_err = 0;
    exp_q.delete();
    repeat (2) tick();
    resetn = 1'b1;
    push_word(18'h1C0DE);
    for (int i = 1; i <= 4; i++) push_word({2'b00, 16'h0101 * 16'(i)});
    push_word(18'h20505);
    drain(400);
    chk("rst_next_frame", {out_hdr, out_data}, {16'hC0DE, 80'h0505_0404_0303_0202_0101});
    chk("rst_next_err", 96'(err_cnt), 96'(0));

    // Randomized streams with sporadic corruption and a random consumer.
    clr_pulse();
    ready_mode = 2;
    for (int s = 0; s < 40; s++) begin
      seg.delete();
      seg.push_back({2'b01, 16'($urandom)});
      for (int i = 0; i < 4; i++) seg.push_back({2'b00, 16'($urandom)});
      seg.push_back({2'b10, 16'($urandom)});
      case ($urandom_range(0, 7))
        0: begin
          k = $urandom_range(0, 5);
          t = seg[k];
          t[17:16] = 2'($urandom_range(0, 3));
          seg[k] = t;
        end
        1: seg.delete(5);
        2: seg.insert(5, {2'b00, 16'($urandom)});
        default: ;
      endcase
      foreach (seg[i]) push_word(seg[i]);
    end
    drain(20000);
    chk("rand_err16", 96'(err_cnt), sat(m_err, 65535));
    chk("rand_err2", 96'(err_small), sat(m_err, 3));
    chk("rand_pending", 96'(exp_q.size()), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
